// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 convolution window controller and datapath.
package window_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StFlush
  } state_e;

  localparam int unsigned DefWidth  = 640;
  localparam int unsigned DefHeight = 480;
  localparam int unsigned PixelW    = 12;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y counter: x wraps at XCount-1 and carries into y, which wraps at YCount-1.
module raster_counter #(
  parameter int unsigned XCount = 640,
  parameter int unsigned YCount = 480,
  localparam int unsigned XW = $clog2(XCount),
  localparam int unsigned YW = $clog2(YCount)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_x_o,
  output logic          last_y_o
);

  logic [XW-1:0] x_d, x_q;
  logic [YW-1:0] y_d, y_q;

  assign last_x_o = (x_q == XW'(XCount - 1));
  assign last_y_o = (y_q == YW'(YCount - 1));
  assign x_o      = x_q;
  assign y_o      = y_q;

  // Clear wins over enable so an idle controller always restarts from (0,0).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (last_x_o) begin
        x_d = '0;
        y_d = last_y_o ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/window_ctrl.sv
// Sequencer for the 3x3 streaming window: input handshake, end-of-frame zero flush and
// per-shift centre tagging (coordinates, valid, border, sof, eol).
module window_ctrl
  import window_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned HEIGHT = DefHeight,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          frame_start_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          out_ready_i,
  output logic          shift_en_o,
  output logic          pad_zero_o,
  output logic          win_valid_o,
  output logic          border_o,
  output logic [XW-1:0] centre_x_o,
  output logic [YW-1:0] centre_y_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  state_e        state_q;
  logic [XW-1:0] in_x, cen_x, cen_x_q;
  logic [YW-1:0] in_y, cen_y, cen_y_q;
  logic          in_last_x, in_last_y, cen_last_x, cen_last_y;
  logic          cnt_clr, shift, centre_en;
  logic          fill_done, run_done, flush_done;
  logic          win_valid_q, border_q, sof_q, eol_q, frame_done_q;

  always_comb begin
    in_ready_o = 1'b0;
    pad_zero_o = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      StFill: begin
        in_ready_o = 1'b1;
        shift      = in_valid_i;
      end
      StRun: begin
        in_ready_o = out_ready_i;
        shift      = in_valid_i & out_ready_i;
      end
      StFlush: begin
        pad_zero_o = 1'b1;
        shift      = out_ready_i;
      end
      default: ;
    endcase
  end

  // Input index n = y*WIDTH + x; n == WIDTH+1 is the first shift that yields a centre,
  // and during flush the counter restarts from 0 so n == WIDTH ends the flush.
  assign fill_done  = (state_q == StFill) && shift &&
                      (in_x == XW'(1)) && (in_y == YW'(1));
  assign run_done   = (state_q == StRun) && shift && in_last_x && in_last_y;
  assign flush_done = (state_q == StFlush) && shift &&
                      (in_x == '0) && (in_y == YW'(1));
  assign centre_en  = shift && ((state_q == StRun) || (state_q == StFlush) || fill_done);
  assign cnt_clr    = (state_q == StIdle);

  raster_counter #(
    .XCount(WIDTH),
    .YCount(HEIGHT)
  ) u_in_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .en_i    (shift),
    .x_o     (in_x),
    .y_o     (in_y),
    .last_x_o(in_last_x),
    .last_y_o(in_last_y)
  );

  raster_counter #(
    .XCount(WIDTH),
    .YCount(HEIGHT)
  ) u_cen_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .en_i    (centre_en),
    .x_o     (cen_x),
    .y_o     (cen_y),
    .last_x_o(cen_last_x),
    .last_y_o(cen_last_y)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      win_valid_q  <= 1'b0;
      border_q     <= 1'b0;
      cen_x_q      <= '0;
      cen_y_q      <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= centre_en;
      frame_done_q <= flush_done;
      // Tags describe the window after this shift; they hold through stalls.
      if (centre_en) begin
        cen_x_q  <= cen_x;
        cen_y_q  <= cen_y;
        border_q <= (cen_x == '0) || cen_last_x || (cen_y == '0) || cen_last_y;
        sof_q    <= (cen_x == '0) && (cen_y == '0);
        eol_q    <= cen_last_x;
      end
      unique case (state_q)
        StIdle:  if (frame_start_i) state_q <= StFill;
        StFill:  if (fill_done)     state_q <= StRun;
        StRun:   if (run_done)      state_q <= StFlush;
        StFlush: if (flush_done)    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign shift_en_o   = shift;
  assign win_valid_o  = win_valid_q;
  assign border_o     = border_q;
  assign centre_x_o   = cen_x_q;
  assign centre_y_o   = cen_y_q;
  assign sof_o        = sof_q;
  assign eol_o        = eol_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl at 4x3: reference model queues expected centres per shift.
module tb_window_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned H = 3;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       border;
    logic       sof;
    logic       eol;
  } cen_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, shift_en, pad_zero, win_valid, border, sof, eol, busy, frame_done;
  logic [1:0] centre_x;
  logic [1:0] centre_y;

  cen_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_st = 0;
  int   m_n = 0;
  int   m_cn = 0;
  logic exp_wv = 1'b0;
  logic exp_fd = 1'b0;
  int   shifts = 0;
  int   wvs = 0;
  int   nonborder = 0;

  always #5 clk = ~clk;

  window_ctrl #(
    .WIDTH (W),
    .HEIGHT(H)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_start_i(frame_start),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_ready_i  (out_ready),
    .shift_en_o   (shift_en),
    .pad_zero_o   (pad_zero),
    .win_valid_o  (win_valid),
    .border_o     (border),
    .centre_x_o   (centre_x),
    .centre_y_o   (centre_y),
    .sof_o        (sof),
    .eol_o        (eol),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".shift_en"}, 32'(shift_en), 0);
    chk({tag, ".pad_zero"}, 32'(pad_zero), 0);
    chk({tag, ".win_valid"}, 32'(win_valid), 0);
    chk({tag, ".border"}, 32'(border), 0);
    chk({tag, ".centre_x"}, 32'(centre_x), 0);
    chk({tag, ".centre_y"}, 32'(centre_y), 0);
    chk({tag, ".sof"}, 32'(sof), 0);
    chk({tag, ".eol"}, 32'(eol), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
  endtask

  // One clock: drive inputs at negedge, check registered results of the previous edge,
  // check the combinational handshake, then advance the model for the coming edge.
  task automatic step(input logic fs, input logic iv, input logic ordy);
    logic e_rdy, e_sh;
    cen_t e;
    @(negedge clk);
    frame_start = fs;
    in_valid    = iv;
    out_ready   = ordy;
    #1;
    chk("win_valid", 32'(win_valid), 32'(exp_wv));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("busy", 32'(busy), 32'(m_st != 0));
    if (exp_wv) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("centre_x", 32'(centre_x), 32'(e.x));
        chk("centre_y", 32'(centre_y), 32'(e.y));
        chk("border", 32'(border), 32'(e.border));
        chk("sof", 32'(sof), 32'(e.sof));
        chk("eol", 32'(eol), 32'(e.eol));
        wvs++;
        if (border === 1'b0) nonborder++;
      end
    end
    if (exp_fd) begin
      chk("frame_shifts", shifts, W * H + W + 1);
      chk("frame_centres", wvs, W * H);
      chk("frame_nonborder", nonborder, 2);
      chk("queue_drained", exp_q.size(), 0);
      shifts = 0;
      wvs = 0;
      nonborder = 0;
    end
    case (m_st)
      1:       begin e_rdy = 1'b1; e_sh = iv;        end
      2:       begin e_rdy = ordy; e_sh = iv & ordy; end
      3:       begin e_rdy = 1'b0; e_sh = ordy;      end
      default: begin e_rdy = 1'b0; e_sh = 1'b0;      end
    endcase
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("shift_en", 32'(shift_en), 32'(e_sh));
    chk("pad_zero", 32'(pad_zero), 32'(m_st == 3));
    if (shift_en === 1'b1) shifts++;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (m_st == 0) begin
      if (fs) begin
        m_st = 1;
        m_n = 0;
        m_cn = 0;
      end
    end else if (e_sh) begin
      if (m_n >= W + 1) begin
        e.x = 2'(m_cn % W);
        e.y = 2'(m_cn / W);
        e.border = (e.x == 0) || (e.x == W - 1) || (e.y == 0) || (e.y == H - 1);
        e.sof = (m_cn == 0);
        e.eol = (e.x == W - 1);
        exp_q.push_back(e);
        exp_wv = 1'b1;
        m_cn++;
      end
      if (m_st == 1 && m_n == W + 1) m_st = 2;
      else if (m_st == 2 && m_n == W * H - 1) m_st = 3;
      else if (m_st == 3 && m_n == W * H + W) begin
        m_st = 0;
        exp_fd = 1'b1;
      end
      m_n++;
    end
  endtask

  // mode 0: steady flow, 1: random gaps, 2: in_valid low during flush.
  task automatic run_frame(input int mode, input bit midfs);
    int   guard;
    logic iv, ordy, fs;
    guard = 0;
    step(1'b1, 1'b1, 1'b1);
    while (m_st != 0 && guard < 500) begin
      iv = 1'b1;
      ordy = 1'b1;
      fs = 1'b0;
      if (mode == 1) begin
        iv = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
      end
      if (mode == 2 && m_st == 3) iv = 1'b0;
      if (midfs && (guard == 3 || guard == 9 || guard == 14)) fs = 1'b1;
      step(fs, iv, ordy);
      guard++;
    end
    if (guard >= 500) chk("frame_timeout", 1, 0);
  endtask

  initial begin
    int guard;
    #1 rst_n = 1'b0;
    #2 chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);

    run_frame(0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    run_frame(1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset in RUN after eight shifts.
    step(1'b1, 1'b1, 1'b1);
    guard = 0;
    while (shifts < 8 && guard < 50) begin
      step(1'b0, 1'b1, 1'b1);
      guard++;
    end
    if (guard >= 50) chk("reset_setup_timeout", 1, 0);
    #6 rst_n = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    m_st = 0;
    exp_q.delete();
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    shifts = 0;
    wvs = 0;
    nonborder = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 1'b0);
    run_frame(2, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
